// File: rtl/controller_poll_sched_if.sv
// Byte-stream and controller-state bundle between the SPI receiver side and the poll scheduler.
interface controller_poll_sched_if;
   logic [7:0]  byte_in;
   logic        byte_valid_in;
   logic        frame_start_in;
   logic        poll_req_out;
   logic [23:0] controller_out;
   logic        update_out;
   logic        connected_out;
   logic [2:0]  miss_count_out;
   logic        busy_out;

   modport master (
      output byte_in, byte_valid_in, frame_start_in,
      input  poll_req_out, controller_out, update_out, connected_out, miss_count_out, busy_out
   );

   modport slave (
      input  byte_in, byte_valid_in, frame_start_in,
      output poll_req_out, controller_out, update_out, connected_out, miss_count_out, busy_out
   );
endinterface

// File: rtl/controller_poll_sched.sv
// Polls the controller chip, assembles start/button/joystick bytes into a frame and commits it atomically.
// Optional macro CTRL_CHECKSUM_EN appends a CHECK state validating an XOR checksum byte.
module controller_poll_sched #(
   parameter int unsigned POLL_PERIOD = 100000,
   parameter int unsigned TIMEOUT     = 20000,
   parameter int unsigned MAX_MISSES  = 3,
   parameter int unsigned START_CHAR  = 83
) (
   input logic                    clk_in,
   input logic                    rst_n_in,
   controller_poll_sched_if.slave bus
);
   localparam int unsigned PCW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
   localparam int unsigned TCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [23:0] NEUTRAL = 24'h80_80_00;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_START,
      BUTTONS,
      JOY_Y,
      JOY_X
`ifdef CTRL_CHECKSUM_EN
      , CHECK
`endif
   } state_t;

   state_t         state_q, state_d;
   logic [PCW-1:0] poll_cnt_q, poll_cnt_d;
   logic [TCW-1:0] to_cnt_q, to_cnt_d;
   logic           pending_q, pending_d;
   logic [2:0]     idx_q, idx_d;
   logic [7:0]     btn_q, btn_d;
   logic [7:0]     y_q, y_d;
`ifdef CTRL_CHECKSUM_EN
   logic [7:0]     x_q, x_d;
   logic [7:0]     chk_q, chk_d;
`endif
   logic           poll_req_q, poll_req_d;
   logic [23:0]    ctrl_q, ctrl_d;
   logic           upd_q, upd_d;
   logic           conn_q, conn_d;
   logic [2:0]     miss_q, miss_d;
   logic           busy_q, busy_d;

   logic           tick, timeout, commit, miss, chk_bad;
   logic [23:0]    commit_val;
   logic [2:0]     miss_inc;

   assign bus.poll_req_out   = poll_req_q;
   assign bus.controller_out = ctrl_q;
   assign bus.update_out     = upd_q;
   assign bus.connected_out  = conn_q;
   assign bus.miss_count_out = miss_q;
   assign bus.busy_out       = busy_q;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q    <= IDLE;
         poll_cnt_q <= '0;
         to_cnt_q   <= '0;
         pending_q  <= 1'b0;
         idx_q      <= '0;
         btn_q      <= '0;
         y_q        <= '0;
`ifdef CTRL_CHECKSUM_EN
         x_q        <= '0;
         chk_q      <= '0;
`endif
         poll_req_q <= 1'b0;
         ctrl_q     <= NEUTRAL;
         upd_q      <= 1'b0;
         conn_q     <= 1'b0;
         miss_q     <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         poll_cnt_q <= poll_cnt_d;
         to_cnt_q   <= to_cnt_d;
         pending_q  <= pending_d;
         idx_q      <= idx_d;
         btn_q      <= btn_d;
         y_q        <= y_d;
`ifdef CTRL_CHECKSUM_EN
         x_q        <= x_d;
         chk_q      <= chk_d;
`endif
         poll_req_q <= poll_req_d;
         ctrl_q     <= ctrl_d;
         upd_q      <= upd_d;
         conn_q     <= conn_d;
         miss_q     <= miss_d;
         busy_q     <= busy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      btn_d      = btn_q;
      y_d        = y_q;
`ifdef CTRL_CHECKSUM_EN
      x_d        = x_q;
      chk_d      = chk_q;
`endif
      poll_req_d = poll_req_q;
      ctrl_d     = ctrl_q;
      upd_d      = 1'b0;
      conn_d     = conn_q;
      miss_d     = miss_q;
      commit     = 1'b0;
      chk_bad    = 1'b0;
      commit_val = ctrl_q;

      tick       = (poll_cnt_q == PCW'(POLL_PERIOD - 1));
      poll_cnt_d = tick ? '0 : poll_cnt_q + PCW'(1);
      pending_d  = pending_q | tick | bus.frame_start_in;
      timeout    = (state_q != IDLE) && (to_cnt_q == TCW'(TIMEOUT));
      to_cnt_d   = (state_q == IDLE) ? to_cnt_q : to_cnt_q + TCW'(1);
      miss_inc   = (miss_q == 3'd7) ? 3'd7 : miss_q + 3'd1;

      unique case (state_q)
         IDLE: begin
            if (pending_q) begin
               state_d    = WAIT_START;
               pending_d  = tick | bus.frame_start_in;
               poll_req_d = 1'b1;
               to_cnt_d   = '0;
            end
         end
         WAIT_START: begin
            if (bus.byte_valid_in && (bus.byte_in == 8'(START_CHAR))) begin
               state_d    = BUTTONS;
               idx_d      = '0;
               btn_d      = '0;
               poll_req_d = 1'b0;
`ifdef CTRL_CHECKSUM_EN
               chk_d      = '0;
`endif
            end
         end
         BUTTONS: begin
            if (bus.byte_valid_in) begin
               btn_d = {btn_q[6:0], bus.byte_in[0]};
               idx_d = idx_q + 3'd1;
`ifdef CTRL_CHECKSUM_EN
               chk_d = chk_q ^ bus.byte_in;
`endif
               if (idx_q == 3'd7) state_d = JOY_Y;
            end
         end
         JOY_Y: begin
            if (bus.byte_valid_in) begin
               y_d     = bus.byte_in;
               state_d = JOY_X;
`ifdef CTRL_CHECKSUM_EN
               chk_d   = chk_q ^ bus.byte_in;
`endif
            end
         end
         JOY_X: begin
            if (bus.byte_valid_in) begin
`ifdef CTRL_CHECKSUM_EN
               x_d     = bus.byte_in;
               chk_d   = chk_q ^ bus.byte_in;
               state_d = CHECK;
`else
               commit     = 1'b1;
               commit_val = {bus.byte_in, y_q, btn_q};
`endif
            end
         end
`ifdef CTRL_CHECKSUM_EN
         CHECK: begin
            if (bus.byte_valid_in) begin
               commit     = (bus.byte_in == chk_q);
               chk_bad    = (bus.byte_in != chk_q);
               commit_val = {x_q, y_q, btn_q};
            end
         end
`endif
         default: state_d = IDLE;
      endcase

      // A final byte landing on the timeout edge still commits
      miss = !commit && (timeout || chk_bad);

      if (commit) begin
         state_d = IDLE;
         ctrl_d  = commit_val;
         upd_d   = 1'b1;
         conn_d  = 1'b1;
         miss_d  = '0;
      end else if (miss) begin
         state_d    = IDLE;
         poll_req_d = 1'b0;
         miss_d     = miss_inc;
         if (conn_q && (miss_inc == 3'(MAX_MISSES))) begin
            conn_d = 1'b0;
            ctrl_d = NEUTRAL;
            upd_d  = 1'b1;
         end
      end

      busy_d = (state_d != IDLE);
   end
endmodule

// File: tb/tb_controller_poll_sched.sv
// Randomized self-checking bench for controller_poll_sched against a frame-level reference model.
module tb_controller_poll_sched;
   localparam int unsigned P  = 3000;
   localparam int unsigned T  = 40;
   localparam int unsigned MM = 3;
   localparam int unsigned SC = 83;
   localparam logic [23:0] NEUTRAL = 24'h80_80_00;
`ifdef CTRL_CHECKSUM_EN
   localparam int LAST = 11;
`else
   localparam int LAST = 10;
`endif

   logic clk;
   logic rst_n;
   controller_poll_sched_if bus ();

   controller_poll_sched #(
      .POLL_PERIOD(P), .TIMEOUT(T), .MAX_MISSES(MM), .START_CHAR(SC)
   ) dut (
      .clk_in  (clk),
      .rst_n_in(rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int upd_cnt  = 0;
   int m_upd    = 0;
   logic [23:0] m_ctrl;
   logic        m_conn;
   int          m_miss;
   logic [7:0]  f_btn [8];
   logic [7:0]  f_y, f_x;

   always @(negedge clk) if (bus.update_out === 1'b1) upd_cnt++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.byte_in       = b;
      bus.byte_valid_in = 1'b1;
      tick_clk();
      bus.byte_valid_in = 1'b0;
   endtask

   function automatic logic [7:0] exp_buttons();
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[7-i] = f_btn[i][0];
      return b;
   endfunction

   function automatic logic [7:0] frame_xor();
      logic [7:0] c = f_y ^ f_x;
      for (int i = 0; i < 8; i++) c = c ^ f_btn[i];
      return c;
   endfunction

   // Byte index 0 is the start char, 1..8 buttons, 9 y, 10 x, 11 checksum
   task automatic send_range(input int gap_max, input int lo, input int hi);
      logic [7:0] q[$];
      q.push_back(8'(SC));
      for (int i = 0; i < 8; i++) q.push_back(f_btn[i]);
      q.push_back(f_y);
      q.push_back(f_x);
      q.push_back(frame_xor());
      for (int i = lo; i <= hi; i++) begin
         if (i > lo && gap_max > 0) repeat ($urandom_range(gap_max, 0)) tick_clk();
         send_byte(q[i]);
      end
   endtask

   task automatic set_nominal();
      logic [7:0] v;
      v = 8'b1010_0001;
      for (int i = 0; i < 8; i++) f_btn[i] = {7'd0, v[7-i]};
      f_y = 8'h20;
      f_x = 8'hF0;
   endtask

   task automatic set_random();
      for (int i = 0; i < 8; i++) f_btn[i] = 8'($urandom);
      f_y = 8'($urandom);
      f_x = 8'($urandom);
   endtask

   task automatic model_commit();
      m_ctrl = {f_x, f_y, exp_buttons()};
      m_conn = 1'b1;
      m_miss = 0;
      m_upd++;
   endtask

   task automatic model_miss();
      m_miss = (m_miss == 7) ? 7 : m_miss + 1;
      if (m_conn && m_miss == int'(MM)) begin
         m_conn = 1'b0;
         m_ctrl = NEUTRAL;
         m_upd++;
      end
   endtask

   task automatic do_reset();
      bus.byte_in        = '0;
      bus.byte_valid_in  = 1'b0;
      bus.frame_start_in = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      upd_cnt = 0;
      m_upd   = 0;
      m_ctrl  = NEUTRAL;
      m_conn  = 1'b0;
      m_miss  = 0;
      rst_n = 1'b1;
      tick_clk();
   endtask

   task automatic wait_poll(input string name);
      int n = 0;
      while (bus.poll_req_out !== 1'b1 && n < 10) begin
         tick_clk();
         n++;
      end
      n_checks++;
      if (bus.poll_req_out !== 1'b1) begin
         n_fail++;
         $display("FAIL %s: poll_req_out=%b after %0d cycles, required 1", name, bus.poll_req_out, n);
      end
   endtask

   task automatic request_poll(input string name);
      bus.frame_start_in = 1'b1;
      tick_clk();
      bus.frame_start_in = 1'b0;
      wait_poll(name);
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (bus.controller_out !== NEUTRAL) begin
         n_fail++; $display("FAIL reset_ctrl: got %h, required %h", bus.controller_out, NEUTRAL);
      end
      n_checks++;
      if ({bus.poll_req_out, bus.update_out, bus.connected_out, bus.busy_out} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_flags: got %b, required 0000",
                            {bus.poll_req_out, bus.update_out, bus.connected_out, bus.busy_out});
      end
      n_checks++;
      if (bus.miss_count_out !== 3'd0) begin
         n_fail++; $display("FAIL reset_miss: got %0d, required 0", bus.miss_count_out);
      end
   endtask

   task automatic test_nominal();
      do_reset();
      set_nominal();
      bus.frame_start_in = 1'b1;
      tick_clk();
      bus.frame_start_in = 1'b0;
      n_checks++;
      if (bus.poll_req_out !== 1'b0) begin
         n_fail++; $display("FAIL nom_poll_edge1: got %b, required 0", bus.poll_req_out);
      end
      tick_clk();
      n_checks++;
      if ({bus.poll_req_out, bus.busy_out} !== 2'b11) begin
         n_fail++; $display("FAIL nom_poll_edge2: got %b, required 11", {bus.poll_req_out, bus.busy_out});
      end
      send_range(0, 0, 0);
      n_checks++;
      if ({bus.poll_req_out, bus.busy_out} !== 2'b01) begin
         n_fail++; $display("FAIL nom_after_start: got %b, required 01", {bus.poll_req_out, bus.busy_out});
      end
      send_range(0, 1, LAST - 1);
      n_checks++;
      if (bus.controller_out !== NEUTRAL || upd_cnt != 0) begin
         n_fail++; $display("FAIL nom_premature: ctrl %h upd %0d, required %h 0", bus.controller_out, upd_cnt, NEUTRAL);
      end
      send_range(0, LAST, LAST);
      model_commit();
      n_checks++;
      if ({bus.controller_out, bus.update_out, bus.connected_out, bus.miss_count_out} !== {24'hF020A1, 1'b1, 1'b1, 3'd0}) begin
         n_fail++; $display("FAIL nom_commit: ctrl %h upd %b conn %b miss %0d, required f020a1 1 1 0",
                            bus.controller_out, bus.update_out, bus.connected_out, bus.miss_count_out);
      end
      tick_clk();
      n_checks++;
      if ({bus.update_out, bus.busy_out} !== 2'b00 || upd_cnt != m_upd) begin
         n_fail++; $display("FAIL nom_pulse: upd %b busy %b pulses %0d, required 0 0 %0d",
                            bus.update_out, bus.busy_out, upd_cnt, m_upd);
      end
   endtask

   task automatic test_garbage();
      do_reset();
      set_nominal();
      send_byte(8'h00);
      send_byte(8'h55);
      n_checks++;
      if ({bus.busy_out, bus.poll_req_out, bus.update_out} !== 3'b000) begin
         n_fail++; $display("FAIL garb_idle: got %b, required 000", {bus.busy_out, bus.poll_req_out, bus.update_out});
      end
      request_poll("garb_poll");
      send_byte(8'h00);
      send_byte(8'h55);
      n_checks++;
      if (bus.poll_req_out !== 1'b1) begin
         n_fail++; $display("FAIL garb_wait: poll_req %b, required 1", bus.poll_req_out);
      end
      send_range(0, 0, LAST);
      model_commit();
      n_checks++;
      if (bus.controller_out !== m_ctrl || bus.update_out !== 1'b1) begin
         n_fail++; $display("FAIL garb_commit: ctrl %h upd %b, required %h 1", bus.controller_out, bus.update_out, m_ctrl);
      end
   endtask

   task automatic test_timeout();
      int n;
      do_reset();
      set_nominal();
      request_poll("to_setup");
      send_range(0, 0, LAST);
      model_commit();
      for (int k = 1; k <= int'(MM); k++) begin
         request_poll("to_poll");
         n = 0;
         while (bus.busy_out === 1'b1 && n < int'(T) + 10) begin
            tick_clk();
            n++;
         end
         model_miss();
         n_checks++;
         if (n < int'(T) || n > int'(T) + 1) begin
            n_fail++; $display("FAIL to_latency[%0d]: %0d cycles, required %0d..%0d", k, n, T, T + 1);
         end
         n_checks++;
         if ({bus.controller_out, bus.connected_out, bus.miss_count_out, bus.poll_req_out} !== {m_ctrl, m_conn, 3'(m_miss), 1'b0}) begin
            n_fail++; $display("FAIL to_state[%0d]: ctrl %h conn %b miss %0d preq %b, required %h %b %0d 0", k,
                               bus.controller_out, bus.connected_out, bus.miss_count_out, bus.poll_req_out,
                               m_ctrl, m_conn, m_miss);
         end
         tick_clk();
         n_checks++;
         if (upd_cnt != m_upd) begin
            n_fail++; $display("FAIL to_pulses[%0d]: got %0d, required %0d", k, upd_cnt, m_upd);
         end
      end
   endtask

   task automatic test_deferred_poll();
      do_reset();
      set_random();
      request_poll("def_poll");
      send_range(0, 0, 4);
      bus.frame_start_in = 1'b1;
      tick_clk();
      bus.frame_start_in = 1'b0;
      send_range(0, 5, LAST);
      model_commit();
      n_checks++;
      if ({bus.controller_out, bus.poll_req_out, bus.busy_out} !== {m_ctrl, 2'b00}) begin
         n_fail++; $display("FAIL def_commit: ctrl %h preq %b busy %b, required %h 0 0",
                            bus.controller_out, bus.poll_req_out, bus.busy_out, m_ctrl);
      end
      tick_clk();
      n_checks++;
      if (bus.poll_req_out !== 1'b1) begin
         n_fail++; $display("FAIL def_reissue: poll_req %b, required 1", bus.poll_req_out);
      end
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      set_random();
      request_poll("rmf_poll1");
      send_range(0, 0, LAST);
      set_random();
      request_poll("rmf_poll2");
      send_range(0, 0, 4);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.controller_out, bus.poll_req_out, bus.update_out, bus.connected_out, bus.miss_count_out, bus.busy_out} !==
          {NEUTRAL, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0}) begin
         n_fail++; $display("FAIL rmf_async: ctrl %h preq %b upd %b conn %b miss %0d busy %b, required %h 0 0 0 0 0",
                            bus.controller_out, bus.poll_req_out, bus.update_out, bus.connected_out,
                            bus.miss_count_out, bus.busy_out, NEUTRAL);
      end
      do_reset();
      set_random();
      request_poll("rmf_poll3");
      send_range(0, 0, LAST);
      model_commit();
      n_checks++;
      if ({bus.controller_out, bus.connected_out} !== {m_ctrl, 1'b1}) begin
         n_fail++; $display("FAIL rmf_recover: ctrl %h conn %b, required %h 1", bus.controller_out, bus.connected_out, m_ctrl);
      end
   endtask

   task automatic test_auto_poll();
      int n = 1;
      do_reset();
      while (bus.poll_req_out !== 1'b1 && n < int'(P) + 10) begin
         tick_clk();
         n++;
      end
      n_checks++;
      if (n < int'(P) || n > int'(P) + 2) begin
         n_fail++; $display("FAIL auto_period: poll after %0d edges, required %0d..%0d", n, P, P + 2);
      end
      set_random();
      send_range(1, 0, LAST);
      model_commit();
      repeat (4) tick_clk();
      n_checks++;
      if ({bus.controller_out, bus.poll_req_out, bus.busy_out} !== {m_ctrl, 2'b00}) begin
         n_fail++; $display("FAIL auto_commit: ctrl %h preq %b busy %b, required %h 0 0",
                            bus.controller_out, bus.poll_req_out, bus.busy_out, m_ctrl);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      set_random();
      request_poll("b2b_poll1");
      send_range(0, 0, LAST - 1);
      bus.frame_start_in = 1'b1;
      send_range(0, LAST, LAST);
      bus.frame_start_in = 1'b0;
      model_commit();
      n_checks++;
      if (bus.controller_out !== m_ctrl) begin
         n_fail++; $display("FAIL b2b_first: ctrl %h, required %h", bus.controller_out, m_ctrl);
      end
      tick_clk();
      n_checks++;
      if (bus.poll_req_out !== 1'b1) begin
         n_fail++; $display("FAIL b2b_reissue: poll_req %b, required 1", bus.poll_req_out);
      end
      set_random();
      send_range(0, 0, LAST);
      model_commit();
      tick_clk();
      n_checks++;
      if (bus.controller_out !== m_ctrl || upd_cnt != m_upd) begin
         n_fail++; $display("FAIL b2b_second: ctrl %h pulses %0d, required %h %0d", bus.controller_out, upd_cnt, m_ctrl, m_upd);
      end
   endtask

   task automatic test_random();
      logic [7:0] g;
      int n;
      do_reset();
      for (int it = 0; it < 25; it++) begin
         set_random();
         request_poll("rnd_poll");
         repeat ($urandom_range(2, 0)) begin
            do g = 8'($urandom); while (g == 8'(SC));
            send_byte(g);
         end
         if ($urandom_range(4, 0) == 0) begin
            send_range(1, 0, $urandom_range(LAST - 1, 0));
            n = 0;
            while (bus.busy_out === 1'b1 && n < int'(T) + 5) begin
               tick_clk();
               n++;
            end
            model_miss();
         end else begin
            send_range(1, 0, LAST);
            model_commit();
         end
         tick_clk();
         n_checks++;
         if ({bus.controller_out, bus.connected_out, bus.miss_count_out, bus.busy_out} !== {m_ctrl, m_conn, 3'(m_miss), 1'b0}
             || upd_cnt != m_upd) begin
            n_fail++; $display("FAIL rnd[%0d]: ctrl %h conn %b miss %0d busy %b pulses %0d, required %h %b %0d 0 %0d", it,
                               bus.controller_out, bus.connected_out, bus.miss_count_out, bus.busy_out, upd_cnt,
                               m_ctrl, m_conn, m_miss, m_upd);
         end
      end
   endtask

`ifdef CTRL_CHECKSUM_EN
   task automatic test_checksum();
      do_reset();
      set_nominal();
      request_poll("chk_poll1");
      send_range(0, 0, LAST - 1);
      send_byte(8'hD1);
      model_commit();
      n_checks++;
      if (bus.controller_out !== 24'hF020A1 || bus.update_out !== 1'b1) begin
         n_fail++; $display("FAIL chk_good: ctrl %h upd %b, required f020a1 1", bus.controller_out, bus.update_out);
      end
      request_poll("chk_poll2");
      send_range(0, 0, LAST - 1);
      send_byte(8'h00);
      model_miss();
      n_checks++;
      if ({bus.controller_out, bus.miss_count_out, bus.busy_out, bus.update_out} !== {m_ctrl, 3'(m_miss), 2'b00}) begin
         n_fail++; $display("FAIL chk_bad: ctrl %h miss %0d busy %b upd %b, required %h %0d 0 0",
                            bus.controller_out, bus.miss_count_out, bus.busy_out, bus.update_out, m_ctrl, m_miss);
      end
   endtask
`endif

   initial begin
      rst_n              = 1'b0;
      bus.byte_in        = '0;
      bus.byte_valid_in  = 1'b0;
      bus.frame_start_in = 1'b0;
      test_reset();
      test_nominal();
      test_garbage();
      test_timeout();
      test_deferred_poll();
      test_reset_mid_frame();
      test_back_to_back();
      test_random();
`ifdef CTRL_CHECKSUM_EN
      test_checksum();
`endif
      test_auto_poll();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
